// File: rtl/btn_sw_pkg.sv
// Shared definitions for the button/switch controller.
// Holds input counts, the event payload layout and a helper that builds an
// event from a flat channel number (buttons first, then switches).
package btn_sw_pkg;

  localparam int unsigned N_BTN     = 4;
  localparam int unsigned N_SW      = 8;
  localparam int unsigned N_IN      = N_BTN + N_SW;
  localparam int unsigned EVT_IDX_W = 3;
  localparam int unsigned EVT_W     = 1 + EVT_IDX_W + 1;

  typedef enum logic {
    SRC_BTN = 1'b0,
    SRC_SW  = 1'b1
  } src_e;

  // Event layout: [4] source, [3:1] index within source, [0] new level
  typedef struct packed {
    src_e                 src;
    logic [EVT_IDX_W-1:0] idx;
    logic                 level;
  } evt_t;

  // Flat channel 0..N_BTN-1 are buttons, the rest are switches
  function automatic evt_t make_evt(input int unsigned ch, input logic lvl);
    evt_t e;
    e.level = lvl;
    if (ch < N_BTN) begin
      e.src = SRC_BTN;
      e.idx = EVT_IDX_W'(ch);
    end else begin
      e.src = SRC_SW;
      e.idx = EVT_IDX_W'(ch - N_BTN);
    end
    return e;
  endfunction

endpackage

// File: rtl/btn_sw_debounce.sv
// One debounce channel: two-flop synchroniser, agreement counter and level.
// Ports: clk, rst_n, tick (sample strobe), raw (pin), level (debounced),
//        toggle_c (high in the cycle the level is about to flip).
module btn_sw_debounce #(
  parameter int unsigned DB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic toggle_c
);

  localparam int unsigned CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter counts consecutive disagreeing ticks; the last one flips the level
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    toggle_c = 1'b0;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DB_CNT - 1)) begin
          level_d  = ~level_q;
          cnt_d    = '0;
          toggle_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_sw_ctrl.sv
// Board-input controller: debounces 4 buttons and 8 switches, produces change
// pulses and queues change events in a small FIFO read over valid/ready.
// Ports: CLK, RST_ASYNC_N, BTN_IN/SW_IN (raw pins), BTN_LEVEL/SW_LEVEL,
//        BTN_PRESS/SW_CHANGE (pulses), EVT_VALID/EVT_READY/EVT_DATA/EVT_COUNT.
module btn_sw_ctrl
  import btn_sw_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned DB_CNT    = 4,
  parameter int unsigned EVT_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_ASYNC_N,
  input  logic [N_BTN-1:0]           BTN_IN,
  input  logic [N_SW-1:0]            SW_IN,
  output logic [N_BTN-1:0]           BTN_LEVEL,
  output logic [N_SW-1:0]            SW_LEVEL,
  output logic [N_BTN-1:0]           BTN_PRESS,
  output logic [N_SW-1:0]            SW_CHANGE,
  output logic                       EVT_VALID,
  input  logic                       EVT_READY,
  output logic [EVT_W-1:0]           EVT_DATA,
  output logic [$clog2(EVT_DEPTH):0] EVT_COUNT
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned PTR_W  = $clog2(EVT_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SEL_W  = $clog2(N_IN);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_c;
  logic [N_IN-1:0]   raw_all, level_all, toggle_all;
  logic [N_IN-1:0]   pend_q, pend_d;
  logic [N_BTN-1:0]  press_q, press_d;
  logic [N_SW-1:0]   change_q, change_d;
  evt_t              mem_q [EVT_DEPTH];
  evt_t              mem_d [EVT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  sel_c;
  logic              any_c, push_c, pop_c, full_c;
  evt_t              push_evt_c;

  // Free-running sample tick, one cycle wide at the top of the count
  always_comb begin
    tick_c     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  assign raw_all = {SW_IN, BTN_IN};

  for (genvar g = 0; g < int'(N_IN); g++) begin : g_db
    btn_sw_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk      (CLK),
      .rst_n    (RST_ASYNC_N),
      .tick     (tick_c),
      .raw      (raw_all[g]),
      .level    (level_all[g]),
      .toggle_c (toggle_all[g])
    );
  end

  // Pulses line up with the level edge: a button pulses only when rising
  always_comb begin
    press_d  = toggle_all[N_BTN-1:0] & ~level_all[N_BTN-1:0];
    change_d = toggle_all[N_IN-1:N_BTN];
  end

  // Scheduler: lowest pending channel wins; new toggles override the clear
  always_comb begin
    pop_c  = valid_q & EVT_READY;
    full_c = (count_q == CNT_W'(EVT_DEPTH));
    sel_c  = '0;
    any_c  = 1'b0;
    for (int i = int'(N_IN) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_c = SEL_W'(i);
        any_c = 1'b1;
      end
    end
    push_c     = any_c & (~full_c | pop_c);
    push_evt_c = make_evt(32'(sel_c), level_all[sel_c]);
    pend_d     = pend_q;
    if (push_c) pend_d[sel_c] = 1'b0;
    pend_d = pend_d | toggle_all;
  end

  // FIFO bookkeeping; a push into an empty FIFO shows up one cycle later
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = push_evt_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      tick_cnt_q <= '0;
      pend_q     <= '0;
      press_q    <= '0;
      change_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < int'(EVT_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pend_q     <= pend_d;
      press_q    <= press_d;
      change_q   <= change_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      mem_q      <= mem_d;
    end
  end

  assign BTN_LEVEL = level_all[N_BTN-1:0];
  assign SW_LEVEL  = level_all[N_IN-1:N_BTN];
  assign BTN_PRESS = press_q;
  assign SW_CHANGE = change_q;
  assign EVT_VALID = valid_q;
  assign EVT_DATA  = mem_q[rd_ptr_q];
  assign EVT_COUNT = count_q;

endmodule

// File: tb/tb_btn_sw_ctrl.sv
// Bench for btn_sw_ctrl: directed scenarios followed by random pin activity,
// every cycle compared against a behavioural model of pins, ticks and queue.
module tb_btn_sw_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int DB_CNT    = 3;
  localparam int EVT_DEPTH = 4;
  localparam int N         = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = '0;
  logic [7:0] sw_in = '0;
  logic       evt_ready = 1'b0;
  logic [3:0] btn_level, btn_press;
  logic [7:0] sw_level, sw_change;
  logic       evt_valid;
  logic [4:0] evt_data;
  logic [2:0] evt_count;

  btn_sw_ctrl #(.TICK_DIV(TICK_DIV), .DB_CNT(DB_CNT), .EVT_DEPTH(EVT_DEPTH)) dut (
    .CLK         (clk),
    .RST_ASYNC_N (rst_n),
    .BTN_IN      (btn_in),
    .SW_IN       (sw_in),
    .BTN_LEVEL   (btn_level),
    .SW_LEVEL    (sw_level),
    .BTN_PRESS   (btn_press),
    .SW_CHANGE   (sw_change),
    .EVT_VALID   (evt_valid),
    .EVT_READY   (evt_ready),
    .EVT_DATA    (evt_data),
    .EVT_COUNT   (evt_count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model state: cycles since reset, pin history, accepted levels, run
  // lengths of disagreement, changed-but-unreported flags, event queue
  int         m_cyc;
  bit         m_seen1 [N];
  bit         m_seen2 [N];
  bit         m_lvl   [N];
  int         m_run   [N];
  bit         m_dirty [N];
  bit         m_pulse [N];
  logic [4:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_seen1[i] = 0; m_seen2[i] = 0; m_lvl[i] = 0;
      m_run[i] = 0; m_dirty[i] = 0; m_pulse[i] = 0;
    end
  endtask

  // Advance the model by one clock using the pins as they are now
  task automatic model_step();
    bit         tick, pop;
    int         sel;
    logic [11:0] raw;
    logic [4:0] ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw  = {sw_in, btn_in};
    tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    m_cyc++;
    pop = (m_q.size() != 0) && evt_ready;
    sel = -1;
    for (int i = N - 1; i >= 0; i--) if (m_dirty[i]) sel = i;
    if (pop) void'(m_q.pop_front());
    if (sel >= 0 && (m_q.size() < EVT_DEPTH)) begin
      if (sel < 4) ev = {1'b0, 3'(sel), m_lvl[sel]};
      else         ev = {1'b1, 3'(sel - 4), m_lvl[sel]};
      m_q.push_back(ev);
      m_dirty[sel] = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_pulse[i] = 0;
      if (tick) begin
        if (m_seen2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB_CNT) begin
            m_lvl[i]   = ~m_lvl[i];
            m_run[i]   = 0;
            m_dirty[i] = 1;
            m_pulse[i] = (i < 4) ? m_lvl[i] : 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_seen2[i] = m_seen1[i];
      m_seen1[i] = raw[i];
    end
  endtask

  task automatic check_all();
    logic [11:0] ml, mp;
    for (int i = 0; i < N; i++) begin
      ml[i] = m_lvl[i];
      mp[i] = m_pulse[i];
    end
    chk("btn_level", 32'(btn_level), 32'(ml[3:0]));
    chk("sw_level",  32'(sw_level),  32'(ml[11:4]));
    chk("btn_press", 32'(btn_press), 32'(mp[3:0]));
    chk("sw_change", 32'(sw_change), 32'(mp[11:4]));
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    chk("evt_count", 32'(evt_count), 32'(m_q.size()));
    if (m_q.size() != 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_lvl(input int idx, input bit v, input int maxc, output int n);
    logic [11:0] lv;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < maxc) begin
      cyc();
      n++;
      lv = {sw_level, btn_level};
      if (lv[idx] == v) found = 1;
    end
    chk("wait_level", 32'(found), 32'd1);
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    while (!evt_valid && n < maxc) begin
      cyc();
      n++;
    end
    chk("wait_valid", 32'(evt_valid), 32'd1);
  endtask

  task automatic pop_expect(input string tag, input logic [4:0] e);
    chk(tag, 32'(evt_data), 32'(e));
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
  endtask

  initial begin
    int n, pc;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("reset_data", 32'(evt_data), 32'd0);
    rst_n = 1'b1;

    // Clean press on button 2
    btn_in[2] = 1'b1;
    wait_lvl(2, 1'b1, 20, n);
    chk("press_latency_ok", 32'(n >= 11 && n <= 15), 32'd1);
    chk("press_pulse", 32'(btn_press), 32'b0100);
    cyc();
    chk("press_pulse_end", 32'(btn_press), 32'd0);
    wait_valid(5);
    chk("t1_data", 32'(evt_data), 32'b00101);
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk("t1_valid_after_pop", 32'(evt_valid), 32'd0);
    chk("t1_count_after_pop", 32'(evt_count), 32'd0);

    // Glitch on button 1 is rejected
    btn_in[1] = 1'b1;
    run(6);
    btn_in[1] = 1'b0;
    run(20);
    chk("glitch_level", 32'(btn_level[1]), 32'd0);
    chk("glitch_no_evt", 32'(evt_valid), 32'd0);

    // Simultaneous settle of SW7, SW0, BTN3
    sw_in[7] = 1'b1; sw_in[0] = 1'b1; btn_in[3] = 1'b1;
    wait_lvl(3, 1'b1, 20, n);
    chk("sim_btn3_pulse", 32'(btn_press[3]), 32'd1);
    chk("sim_sw_pulses", 32'({sw_change[7], sw_change[0]}), 32'b11);
    run(5);
    chk("sim_count", 32'(evt_count), 32'd3);
    pop_expect("sim_ord0", 5'b00111);
    pop_expect("sim_ord1", 5'b10001);
    pop_expect("sim_ord2", 5'b11111);

    // Back-pressure with six changes and a four-entry queue
    btn_in[2] = 1'b0; btn_in[3] = 1'b0; sw_in[0] = 1'b0; sw_in[7] = 1'b0;
    sw_in[1] = 1'b1; sw_in[2] = 1'b1;
    run(30);
    chk("full_count", 32'(evt_count), 32'd4);
    pop_expect("bp_ord0", 5'b00100);
    pop_expect("bp_ord1", 5'b00110);
    pop_expect("bp_ord2", 5'b10000);
    pop_expect("bp_ord3", 5'b10011);
    pop_expect("bp_ord4", 5'b10101);
    pop_expect("bp_ord5", 5'b11110);
    run(2);
    chk("bp_empty", 32'(evt_valid), 32'd0);

    // Collapse of SW4 toggles while the queue is full
    btn_in[0] = 1'b1; btn_in[1] = 1'b1; sw_in[3] = 1'b1; sw_in[6] = 1'b1;
    run(30);
    chk("col_full", 32'(evt_count), 32'd4);
    sw_in[4] = 1'b1;
    wait_lvl(8, 1'b1, 20, n);
    pc = int'(sw_change[4]);
    sw_in[4] = 1'b0;
    wait_lvl(8, 1'b0, 20, n);
    pc += int'(sw_change[4]);
    chk("col_pulses", 32'(pc), 32'd2);
    run(3);
    pop_expect("col_ord0", 5'b00001);
    pop_expect("col_ord1", 5'b00011);
    pop_expect("col_ord2", 5'b10111);
    pop_expect("col_ord3", 5'b11101);
    pop_expect("col_ord4", 5'b11000);
    run(3);
    chk("col_empty", 32'(evt_valid), 32'd0);

    // Return all pins low and drain
    btn_in = '0; sw_in = '0; evt_ready = 1'b1;
    run(40);
    evt_ready = 1'b0;
    chk("clean_empty", 32'(evt_valid), 32'd0);

    // Reset with two queued events and SW5 mid-debounce
    btn_in[0] = 1'b1;
    run(20);
    btn_in[0] = 1'b0;
    run(20);
    chk("rst_pre_count", 32'(evt_count), 32'd2);
    sw_in[5] = 1'b1;
    run(5);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_data", 32'(evt_data), 32'd0);
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    wait_valid(30);
    chk("rst_sw5_evt", 32'(evt_data), 32'b11011);
    run(5);
    chk("rst_only_one", 32'(evt_count), 32'd1);
    evt_ready = 1'b1;
    run(2);

    // Random pin activity with bursty consumer
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, 11);
        if (n < 4) btn_in[n] = ~btn_in[n];
        else       sw_in[n - 4] = ~sw_in[n - 4];
      end
      if (((c / 60) % 2) == 0) evt_ready = 1'b0;
      else                     evt_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
